imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-fetch sequencer for the 64-word instruction ROM (`imem`). It owns the program counter, drives the ROM word address and captures the combinational read data into a 2-entry fetch buffer. The buffer is presented to decode over a valid/ready handshake. It handles branch/jump redirects from execute and flags out-of-range or misaligned fetches.

## Interface
Parameters:
- `N`, 32, instruction width (matches `imem` `N`)
- `AW`, 6, ROM word-address width (64 words)
- `PCW`, 64, program-counter width in bits
- `RESET_PC`, 0, byte address fetched after reset

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `imem_addr`  out  AW  word address to `imem.addr`, always equal to `pc[AW+1:2]`
- `imem_q`  in  N  combinational ROM data for `imem_addr`
- `redirect_valid`  in  1  load new PC this cycle
- `redirect_pc`  in  PCW  redirect target, byte address
- `if_valid`  out  1  buffer head holds an instruction
- `if_ready`  in  1  decode accepts the head this cycle
- `if_instr`  out  N  head instruction
- `if_pc`  out  PCW  byte address of head instruction
- `if_fault`  out  1  head is a fault marker; `if_instr` = NOP 0x00000013

## Operation
- State: `pc` (PCW), 2-entry FIFO of {instr, pc, fault}, `count` 0..2, FSM {IDLE, RUN, FAULT}.
- Reset (`reset_n`=0 at edge): `pc`=RESET_PC, `count`=0, state=IDLE. Outputs read `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_fault`=0, and `imem_addr`=RESET_PC[AW+1:2].
- IDLE -> RUN unconditionally on the next edge. No enqueue in IDLE.
- Fault condition: `pc[1:0]`≠0 or `pc[PCW-1:AW+2]`≠0.
- Enqueue: state=RUN, no redirect, and (`count`<2 or dequeue this cycle).
  - Pushes {`imem_q`, `pc`, 0}, or {0x00000013, `pc`, 1} under the fault condition.
  - Non-fault push: `pc`<=`pc`+4. Fault push: `pc` holds and state -> FAULT.
- FAULT: no enqueue; existing entries drain normally. Exit only by redirect or reset.
- Dequeue: `if_valid` && `if_ready`. Simultaneous enqueue and dequeue keeps `count` unchanged.
- Redirect has priority over everything:
  - FIFO flushed (`count`<=0) and `pc`<=`redirect_pc`; no enqueue that cycle.
  - State <= RUN from RUN or FAULT. Redirect in IDLE also -> RUN.
  - A dequeue in the redirect cycle is void; decode must discard it.
- Outputs come from the FIFO head. `if_instr`/`if_pc`/`if_fault` are 0 when `count`=0.
- FIFO ordering strictly preserved: no drop, no duplicate.
- `pc` arithmetic is modulo 2^PCW. Overflow is unreachable because the fault check precedes it.

## Timing
- Reset release at edge E0 -> RUN at E1. First push at E2 -> `if_valid`=1 from E2.
- Steady state with `if_ready`=1: one instruction per cycle, `if_pc` advancing by 4.
- Redirect sampled at edge R: `if_valid`=0 in cycle after R; target instruction valid after R+1. Redirect-to-valid latency is 2 cycles.
- Backpressure: `if_ready`=0 for ≥2 cycles fills the FIFO; `pc` and `imem_addr` then hold. After `if_ready` rises, throughput returns to 1/cycle with no bubble.
- Outputs are registered (FIFO storage); `imem_addr` is combinational from `pc` only.
- Reset mid-operation overrides redirect, handshake and FIFO contents in the same edge.

## Test plan
- Reset then `if_ready`=1 -> first `if_valid` two edges after release. Sequence (pc, instr): (0x0, 0x00003023), (0x4, 0x00000f93), (0x8, 0x40000113), (0xC, 0x0940006f), all `if_fault`=0.
- `if_ready`=0 for 5 cycles from reset -> `count`=2, heads pc 0x0/0x4 held, `imem_addr`=2 stable. Raise `if_ready` -> pcs 0x0, 0x4, 0x8 on consecutive cycles, no gap or repeat.
- FIFO full, `redirect_valid`=1 with `redirect_pc`=0xA0 -> next cycle `if_valid`=0. Following cycle (pc 0xA0, 0xfe010113), then (0xA4, 0x00113c23).
- Redirect to 0xD4 in the same cycle as an accepted handshake -> accepted entry voided. Next valid is (0xD4, 0xffdff06f), then (0xD8, 0x00000000).
- Redirect to 0xFC -> (0xFC, 0x00000000, fault 0) then (0x100, 0x00000013, fault 1), then `if_valid`=0 indefinitely. Redirect to 0x10 recovers with (0x10, 0xfd010113).
- Misaligned redirect to 0x2 -> single entry (0x2, 0x00000013, fault 1). Assert `reset_n`=0 mid-stream -> next cycle `if_valid`=0, `imem_addr`=0.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses the instruction ROM and
// buffers fetched words in a 2-entry FIFO presented to decode.
module imem_fetch_ctrl #(
  parameter int N   = 32,
  parameter int AW  = 6,
  parameter int PCW = 64,
  parameter logic [PCW-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic [AW-1:0]  imem_addr,
  input  logic [N-1:0]   imem_q,
  input  logic           redirect_valid,
  input  logic [PCW-1:0] redirect_pc,
  output logic           if_valid,
  input  logic           if_ready,
  output logic [N-1:0]   if_instr,
  output logic [PCW-1:0] if_pc,
  output logic           if_fault
);

  // Handshake: an entry moves to decode on a rising edge where if_valid and
  // if_ready are both high; a redirect in the same cycle voids that transfer.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [N-1:0] NOP = N'(32'h0000_0013);

  state_t         state, state_next;
  logic [PCW-1:0] pc;
  logic [1:0]     count, count_next;
  logic           wr_ptr, rd_ptr;
  logic           fault_cond;
  logic           enq, deq;

  logic [N-1:0]   instr_mem [2];
  logic [PCW-1:0] pc_mem    [2];
  logic           fault_mem [2];

  assign imem_addr  = pc[AW+1:2];
  assign fault_cond = (pc[1:0] != 2'b00) || (pc[PCW-1:AW+2] != '0);

  assign if_valid = (count != 2'd0);
  assign if_instr = if_valid ? instr_mem[rd_ptr] : '0;
  assign if_pc    = if_valid ? pc_mem[rd_ptr]    : '0;
  assign if_fault = if_valid ? fault_mem[rd_ptr] : 1'b0;

  always_comb begin
    state_next = state;
    deq        = if_valid && if_ready;
    enq        = (state == RUN) && !redirect_valid && ((count < 2'd2) || deq);
    count_next = count;
    case (state)
      IDLE:    state_next = RUN;
      RUN:     if (enq && fault_cond) state_next = FAULT;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
    if (redirect_valid) state_next = RUN;
    case ({enq, deq})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
    if (redirect_valid) count_next = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (redirect_valid) begin
        pc     <= redirect_pc;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (enq) begin
          wr_ptr <= ~wr_ptr;
          // A faulting fetch parks the PC so the marker is pushed only once.
          if (!fault_cond) pc <= pc + PCW'(4);
        end
        if (deq) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Storage needs no reset: outputs are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (reset_n && enq) begin
      instr_mem[wr_ptr] <= fault_cond ? NOP : imem_q;
      pc_mem[wr_ptr]    <= pc;
      fault_mem[wr_ptr] <= fault_cond;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: per-cycle vector table, fault/latency sequences
// and a random-backpressure stream checked against an expected-PC queue.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_fault;

  int total = 0;
  int bad   = 0;

  logic [31:0] rom [64];
  assign imem_q = rom[imem_addr];

  imem_fetch_ctrl dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_q(imem_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_fault(if_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, rdy, rv;
    logic [63:0] rpc;
    logic        v;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        f;
    logic [5:0]  addr;
  } vec_t;

  vec_t tbl[$];
  logic [63:0] exp_q[$];

  task automatic add(input logic rst_n, rdy, rv, input logic [63:0] rpc,
                     input logic v, input logic [63:0] pc,
                     input logic [31:0] instr, input logic f, input logic [5:0] addr);
    vec_t e;
    e.rst_n = rst_n; e.rdy = rdy; e.rv = rv; e.rpc = rpc;
    e.v = v; e.pc = pc; e.instr = instr; e.f = f; e.addr = addr;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got v/pc/instr/f/addr=%h want %h", name, act, exp);
    end
  endtask

  function automatic logic [103:0] outs();
    return {if_valid, if_pc, if_instr, if_fault, imem_addr};
  endfunction

  task automatic step(input logic rst_n, rdy, rv, input logic [63:0] rpc);
    reset_n = rst_n; if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0]  = 32'h00003023; rom[1]  = 32'h00000f93;
    rom[2]  = 32'h40000113; rom[3]  = 32'h0940006f;
    rom[4]  = 32'hfd010113; rom[40] = 32'hfe010113;
    rom[41] = 32'h00113c23; rom[53] = 32'hffdff06f;
    for (int i = 5; i < 40; i++) rom[i] = 32'h1000_0000 + i;

    reset_n = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // rst rdy rv rpc | v pc instr f addr
    add(0,1,0,0,      0,0,0,0,0);
    add(0,1,0,0,      0,0,0,0,0);
    add(1,1,0,0,      0,0,0,0,0);
    add(1,1,0,0,      1,64'h0,32'h00003023,0,1);
    add(1,1,0,0,      1,64'h4,32'h00000f93,0,2);
    add(1,1,0,0,      1,64'h8,32'h40000113,0,3);
    add(1,1,0,0,      1,64'hC,32'h0940006f,0,4);
    // backpressure from reset
    add(0,0,0,0,      0,0,0,0,0);
    add(1,0,0,0,      0,0,0,0,0);
    add(1,0,0,0,      1,64'h0,32'h00003023,0,1);
    add(1,0,0,0,      1,64'h0,32'h00003023,0,2);
    add(1,0,0,0,      1,64'h0,32'h00003023,0,2);
    add(1,0,0,0,      1,64'h0,32'h00003023,0,2);
    add(1,1,0,0,      1,64'h4,32'h00000f93,0,3);
    add(1,1,0,0,      1,64'h8,32'h40000113,0,4);
    // redirect with FIFO full
    add(1,0,0,0,      1,64'h8,32'h40000113,0,4);
    add(1,0,1,64'hA0, 0,0,0,0,6'h28);
    add(1,0,0,0,      1,64'hA0,32'hfe010113,0,6'h29);
    add(1,1,0,0,      1,64'hA4,32'h00113c23,0,6'h2A);
    // redirect during accepted handshake
    add(1,1,1,64'hD4, 0,0,0,0,6'h35);
    add(1,1,0,0,      1,64'hD4,32'hffdff06f,0,6'h36);
    add(1,1,0,0,      1,64'hD8,32'h00000000,0,6'h37);
    // run off the end of the ROM
    add(1,1,1,64'hFC, 0,0,0,0,6'h3F);
    add(1,1,0,0,      1,64'hFC,32'h00000000,0,0);
    add(1,1,0,0,      1,64'h100,32'h00000013,1,0);
    add(1,1,0,0,      0,0,0,0,0);
    add(1,1,0,0,      0,0,0,0,0);
    add(1,1,1,64'h10, 0,0,0,0,4);
    add(1,1,0,0,      1,64'h10,32'hfd010113,0,5);
    // misaligned redirect
    add(1,1,1,64'h2,  0,0,0,0,0);
    add(1,1,0,0,      1,64'h2,32'h00000013,1,0);
    add(1,1,0,0,      0,0,0,0,0);
    add(1,1,1,64'h8,  0,0,0,0,2);
    add(1,0,0,0,      1,64'h8,32'h40000113,0,3);
    // reset overrides a simultaneous redirect
    add(0,0,1,64'h40, 0,0,0,0,0);
    add(1,1,0,0,      0,0,0,0,0);
    add(1,1,0,0,      1,64'h0,32'h00003023,0,1);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      check($sformatf("vec%0d", i), outs(),
            {tbl[i].v, tbl[i].pc, tbl[i].instr, tbl[i].f, tbl[i].addr});
    end

    // Fault marker held under backpressure, then nothing follows it.
    step(1,0,1,64'h100);
    step(1,0,0,0);
    for (int k = 0; k < 3; k++) begin
      step(1,0,0,0);
      check("fault_hold", outs(), {1'b1, 64'h100, 32'h13, 1'b1, 6'h0});
    end
    for (int k = 0; k < 8; k++) begin
      step(1,1,0,0);
      check("fault_idle", outs(), {1'b0, 64'h0, 32'h0, 1'b0, 6'h0});
    end

    // Redirect-to-valid latency, bounded wait.
    begin
      int lat;
      lat = 0;
      step(1,1,1,64'h20);
      lat = 1;
      while (!if_valid && lat < 6) begin
        step(1,0,0,0);
        lat++;
      end
      total++;
      if (lat != 2 || if_pc !== 64'h20 || if_instr !== rom[8]) begin
        bad++;
        $display("FAIL redir_latency: got lat=%0d pc=%h instr=%h want lat=2 pc=20 instr=%h",
                 lat, if_pc, if_instr, rom[8]);
      end
    end

    // Random backpressure stream from pc 0: order preserved, no drop/dup.
    step(1,1,1,64'h0);
    for (int p = 0; p < 40; p++) exp_q.push_back(64'(p * 4));
    begin
      int got;
      got = 0;
      for (int c = 0; c < 60; c++) begin
        logic rdy;
        logic take;
        rdy  = ($urandom_range(0, 2) != 0);
        take = if_valid && rdy && (exp_q.size() > 0);
        if (take) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          got++;
          check("stream", {1'b1, if_pc, if_instr, if_fault, 6'h0},
                {1'b1, e, rom[e[7:2]], 1'b0, 6'h0});
        end
        step(1, take, 0, 0);
      end
      total++;
      if (got < 10) begin
        bad++;
        $display("FAIL stream_progress: got %0d accepts want >=10", got);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
